// File: rtl/op_loader.sv
// op_loader: receives a length-prefixed byte stream and writes it as 16-bit
// words into operation memory. The processor is held in reset until a load
// completes successfully.
// Optional feature: define OP_LOADER_CHECKSUM_EN to require a trailing 16-bit
// checksum (sum mod 2^16 of all data words) before declaring the load done.
module op_loader #(
   parameter int unsigned MAX_WORDS = 4096,
   parameter logic [15:0] BASE_ADDR = 16'h0000
) (
   input  logic        clock0,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [15:0] mem_address,
   output logic [15:0] mem_data,
   output logic        mem_wren,
   output logic        cpu_reset,
   output logic        done,
   output logic        error
);

`ifdef OP_LOADER_CHECKSUM_EN
   typedef enum logic [3:0] {
      IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CSUM_HI, CSUM_LO, DONE, ERROR
   } state_t;
   // End of data leads into the checksum bytes.
   localparam state_t END_STATE = CSUM_HI;
`else
   typedef enum logic [3:0] {
      IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR
   } state_t;
   localparam state_t END_STATE = DONE;
`endif

   localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

   state_t      state, state_nx;
   logic [7:0]  hi_byte;
   logic [15:0] len;
   logic [15:0] count;
   logic [15:0] count_inc;
   logic [15:0] word;
   logic        accept;
`ifdef OP_LOADER_CHECKSUM_EN
   logic [15:0] sum;
`endif

   assign word      = {hi_byte, rx_data};
   assign count_inc = count + 16'd1;
   assign accept    = rx_valid & rx_ready;

   // State register; reset drops straight to IDLE so a pending write is killed.
   always_ff @(posedge clock0 or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state decode and Moore outputs.
   always_comb begin
      state_nx  = state;
      rx_ready  = 1'b0;
      mem_wren  = 1'b0;
      cpu_reset = 1'b1;
      done      = 1'b0;
      error     = 1'b0;
      case (state)
         IDLE: if (start) state_nx = LEN_HI;
         LEN_HI: begin
            rx_ready = 1'b1;
            if (rx_valid) state_nx = LEN_LO;
         end
         LEN_LO: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               if (word == 16'd0)                state_nx = END_STATE;
               else if ({1'b0, word} > MAX_LEN) state_nx = ERROR;
               else                             state_nx = DATA_HI;
            end
         end
         DATA_HI: begin
            rx_ready = 1'b1;
            if (rx_valid) state_nx = DATA_LO;
         end
         DATA_LO: begin
            rx_ready = 1'b1;
            if (rx_valid) state_nx = WRITE;
         end
         WRITE: begin
            mem_wren = 1'b1;
            state_nx = (count_inc < len) ? DATA_HI : END_STATE;
         end
`ifdef OP_LOADER_CHECKSUM_EN
         CSUM_HI: begin
            rx_ready = 1'b1;
            if (rx_valid) state_nx = CSUM_LO;
         end
         CSUM_LO: begin
            rx_ready = 1'b1;
            if (rx_valid) state_nx = (word == sum) ? DONE : ERROR;
         end
`endif
         DONE: begin
            cpu_reset = 1'b0;
            done      = 1'b1;
            if (start) state_nx = LEN_HI;
         end
         ERROR: begin
            error = 1'b1;
            if (start) state_nx = LEN_HI;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: byte assembly, length capture, write address/data and counters.
   always_ff @(posedge clock0 or posedge reset) begin
      if (reset) begin
         hi_byte     <= '0;
         len         <= '0;
         count       <= '0;
         mem_address <= BASE_ADDR;
         mem_data    <= '0;
`ifdef OP_LOADER_CHECKSUM_EN
         sum         <= '0;
`endif
      end else begin
         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  count       <= '0;
                  len         <= '0;
                  mem_address <= BASE_ADDR;
`ifdef OP_LOADER_CHECKSUM_EN
                  sum         <= '0;
`endif
               end
            end
            LEN_HI, DATA_HI: if (accept) hi_byte <= rx_data;
            LEN_LO:          if (accept) len <= word;
            DATA_LO: begin
               if (accept) begin
                  mem_data <= word;
`ifdef OP_LOADER_CHECKSUM_EN
                  sum      <= sum + word;
`endif
               end
            end
            WRITE: begin
               mem_address <= mem_address + 16'd1;
               count       <= count_inc;
            end
`ifdef OP_LOADER_CHECKSUM_EN
            CSUM_HI: if (accept) hi_byte <= rx_data;
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_op_loader.sv
// tb_op_loader: table-driven stream vectors with a write scoreboard, plus
// hand-written sequences for start-ignore, length boundary and reset-in-WRITE.
// Expectations follow OP_LOADER_CHECKSUM_EN when it is defined.
module tb_op_loader;
   localparam logic [15:0] BASE = 16'h0000;
   localparam int unsigned MAXW = 4096;

   logic        clock0 = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [15:0] mem_address;
   logic [15:0] mem_data;
   logic        mem_wren;
   logic        cpu_reset;
   logic        done;
   logic        error;

   always #5 clock0 = ~clock0;

   op_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
      .clock0(clock0), .reset(reset), .start(start),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
      .cpu_reset(cpu_reset), .done(done), .error(error)
   );

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
   } wr_t;

   typedef struct {
      string        name;
      int           nbytes;
      logic [127:0] stream;
      bit           jitter;
      bit           exp_done;
      bit           exp_error;
   } vec_t;

   wr_t  exp_q[$];
   vec_t vecs[8];
   int   nvec  = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_wr  = 0;

   task automatic check1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard: every write the DUT makes must match the next expected write.
   always @(negedge clock0) begin
      if (mem_wren === 1'b1) begin
         wr_t e;
         n_wr++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write",
                     mem_address, mem_data);
         end else begin
            e = exp_q.pop_front();
            check16("wr_addr", mem_address, e.addr);
            check16("wr_data", mem_data, e.data);
         end
      end
   end

   task automatic add_vec(input string nm, input int nb, input logic [127:0] s,
                          input bit jit, input bit d, input bit e);
      vecs[nvec].name      = nm;
      vecs[nvec].nbytes    = nb;
      vecs[nvec].stream    = s;
      vecs[nvec].jitter    = jit;
      vecs[nvec].exp_done  = d;
      vecs[nvec].exp_error = e;
      nvec++;
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input bit jit);
      bit got = 1'b0;
      int tries = 0;
      while (!got) begin
         if (jit && $urandom_range(0, 2) == 0) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
         end else begin
            rx_valid = 1'b1;
            rx_data  = b;
         end
         @(negedge clock0);
         got = rx_valid && (rx_ready === 1'b1);
         @(posedge clock0);
         #1;
         tries++;
         if (!got && tries > 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_timeout: byte %h not accepted within 200 cycles", b);
            got = 1'b1;
         end
      end
      rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clock0);
      #1;
      start = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock0);
      #1;
      reset = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      logic [7:0]  b, prev;
      logic [15:0] n;
      int          nwords, wr0;
      n      = {v.stream[8*(v.nbytes-1) +: 8], v.stream[8*(v.nbytes-2) +: 8]};
      nwords = (int'(n) <= int'(MAXW)) ? int'(n) : 0;
      wr0    = n_wr;
      pulse_start();
      check1({v.name, "_start_cpu_reset"}, cpu_reset, 1'b1);
      check1({v.name, "_start_ready"}, rx_ready, 1'b1);
      prev = '0;
      for (int i = 0; i < v.nbytes; i++) begin
         b = v.stream[8*(v.nbytes-1-i) +: 8];
         if (i >= 3 && i < 2 + 2*nwords && (i % 2) == 1)
            exp_q.push_back('{addr: 16'(int'(BASE) + (i-3)/2), data: {prev, b}});
         send_byte(b, v.jitter);
         prev = b;
      end
      repeat (3) @(posedge clock0);
      #1;
      check1({v.name, "_done"}, done, v.exp_done);
      check1({v.name, "_error"}, error, v.exp_error);
      check1({v.name, "_cpu_reset"}, cpu_reset, !v.exp_done);
      check16({v.name, "_nwrites"}, 16'(n_wr - wr0), 16'(nwords));
      check16({v.name, "_pending"}, 16'(exp_q.size()), 16'd0);
      check16({v.name, "_end_addr"}, mem_address, 16'(int'(BASE) + nwords));
      // Trailing bytes must not be accepted.
      rx_valid = 1'b1;
      rx_data  = 8'h55;
      @(negedge clock0);
      check1({v.name, "_extra_ready"}, rx_ready, 1'b0);
      @(posedge clock0);
      #1;
      rx_valid = 1'b0;
      check1({v.name, "_done_hold"}, done, v.exp_done);
   endtask

   initial begin
      int wr0;
      reset    = 1'b1;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = '0;

`ifdef OP_LOADER_CHECKSUM_EN
      add_vec("two_words",  8,  128'h0002_1234_ABCD_BE01,          0, 1, 0);
      add_vec("bad_csum",   8,  128'h0002_1234_ABCD_BE02,          0, 0, 1);
      add_vec("zero_len",   4,  128'h0000_0000,                    0, 1, 0);
      add_vec("too_long",   2,  128'h1001,                         0, 0, 1);
      add_vec("three_b2b",  10, 128'h0003_1111_2222_3333_6666,     0, 1, 0);
      add_vec("three_jit",  10, 128'h0003_1111_2222_3333_6666,     1, 1, 0);
      add_vec("three_jit2", 10, 128'h0003_0102_8000_FFFF_8101,     1, 1, 0);
`else
      add_vec("two_words",  6,  128'h0002_1234_ABCD,               0, 1, 0);
      add_vec("zero_len",   2,  128'h0000,                         0, 1, 0);
      add_vec("too_long",   2,  128'h1001,                         0, 0, 1);
      add_vec("three_b2b",  8,  128'h0003_1111_2222_3333,          0, 1, 0);
      add_vec("three_jit",  8,  128'h0003_1111_2222_3333,          1, 1, 0);
      add_vec("three_jit2", 8,  128'h0003_0102_8000_FFFF,          1, 1, 0);
`endif

      // Reset state, checked while reset is held and after release.
      repeat (2) @(posedge clock0);
      #1;
      check1("rst_ready", rx_ready, 1'b0);
      check1("rst_wren", mem_wren, 1'b0);
      check16("rst_addr", mem_address, BASE);
      check16("rst_data", mem_data, 16'h0000);
      check1("rst_cpu_reset", cpu_reset, 1'b1);
      check1("rst_done", done, 1'b0);
      check1("rst_error", error, 1'b0);
      reset = 1'b0;
      repeat (4) @(posedge clock0);
      #1;
      check1("idle_ready", rx_ready, 1'b0);
      check1("idle_cpu_reset", cpu_reset, 1'b1);

      for (int k = 0; k < nvec; k++) run_vec(vecs[k]);

      // Start mid-word is ignored; the load completes normally.
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'h12, 0);
      pulse_start();
      exp_q.push_back('{addr: BASE, data: 16'h1234});
      send_byte(8'h34, 0);
`ifdef OP_LOADER_CHECKSUM_EN
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
`endif
      repeat (2) @(posedge clock0);
      #1;
      check1("midstart_done", done, 1'b1);
      check16("midstart_pending", 16'(exp_q.size()), 16'd0);

      // Length exactly MAX_WORDS is accepted (still waiting for data).
      pulse_start();
      send_byte(8'h10, 0);
      send_byte(8'h00, 0);
      check1("maxlen_error", error, 1'b0);
      check1("maxlen_ready", rx_ready, 1'b1);
      do_reset();

      // Reset in the cycle of the first WRITE kills the write immediately.
      wr0 = n_wr;
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      check1("pre_reset_wren", mem_wren, 1'b1);
      reset = 1'b1;
      #1;
      check1("wrrst_wren", mem_wren, 1'b0);
      check1("wrrst_cpu_reset", cpu_reset, 1'b1);
      check1("wrrst_ready", rx_ready, 1'b0);
      check16("wrrst_addr", mem_address, BASE);
      repeat (2) @(posedge clock0);
      #1;
      reset = 1'b0;
      repeat (4) @(posedge clock0);
      #1;
      check16("wrrst_nwrites", 16'(n_wr - wr0), 16'd0);
      check1("wrrst_idle_ready", rx_ready, 1'b0);
      check1("wrrst_idle_done", done, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/op_loader.md
OP_LOADER -- requirements
Module: op_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 4096: largest accepted program length in words.
REQ-002 SHALL have parameter BASE_ADDR, default 16'h0000: operation-memory address of the first program word.
REQ-003 SHALL have port clock0, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle pulse that begins a load.
REQ-006 SHALL have port rx_data, input, 8 bits: incoming program byte.
REQ-007 SHALL have port rx_valid, input, 1 bit: rx_data is valid.
REQ-008 SHALL have port rx_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-009 SHALL have port mem_address, output, 16 bits: operation-memory write address.
REQ-010 SHALL have port mem_data, output, 16 bits: operation-memory write data.
REQ-011 SHALL have port mem_wren, output, 1 bit: operation-memory write enable.
REQ-012 SHALL have port cpu_reset, output, 1 bit: drives the processor reset, so the fetch PC is held at 0 while loading.
REQ-013 SHALL have port done, output, 1 bit: load completed successfully.
REQ-014 SHALL have port error, output, 1 bit: load aborted.

Function
REQ-015 SHALL accept a byte only on a rising edge where rx_valid=1 and rx_ready=1.
REQ-016 SHALL assemble each 16-bit word from two bytes, high byte first.
REQ-017 SHALL use these states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CSUM_HI, CSUM_LO, DONE, ERROR.
REQ-018 SHALL drive rx_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI and CSUM_LO.
REQ-019 SHALL move from IDLE, DONE or ERROR to LEN_HI on start=1, with cpu_reset=1, done=0, error=0, word count cleared and mem_address=BASE_ADDR.
REQ-020 SHALL ignore start in all other states.
REQ-021 SHALL treat the first word as length N.
REQ-022 On LEN_LO acceptance: N=0 -> end-of-data handling (REQ-026); N>MAX_WORDS -> ERROR; otherwise -> DATA_HI.
REQ-023 On DATA_LO acceptance, SHALL latch the word into mem_data and enter WRITE.
REQ-024 SHALL hold mem_wren=1 for exactly the one WRITE cycle, with mem_address and mem_data stable, which is the cycle after the low byte is accepted.
REQ-025 On leaving WRITE, SHALL increment mem_address (mod 2^16 wrap) and the word count, then go to DATA_HI if count<N, else to end-of-data handling.
REQ-026 End-of-data handling SHALL follow REQ-036/REQ-037.
REQ-027 In DONE, SHALL hold done=1 and cpu_reset=0, with rx_ready=0 and mem_wren=0.
REQ-028 In ERROR, SHALL hold error=1 and cpu_reset=1; the only exit is start or reset.
REQ-029 SHALL never write more than N words; extra bytes after the final word are not accepted (rx_ready=0).
REQ-030 If rx_valid drops mid-word, SHALL hold state and the partial byte indefinitely; there is no timeout.

Reset
REQ-031 On reset=1, SHALL asynchronously force state IDLE, rx_ready=0, mem_wren=0, mem_address=BASE_ADDR, mem_data=0, cpu_reset=1, done=0, error=0, and count, length and checksum to 0.
REQ-032 Reset during any load SHALL abandon it with no further memory write; a write whose edge coincides with reset release SHALL NOT occur.
REQ-033 After reset the block SHALL stay in IDLE until start.

Configuration
REQ-034 Macro OP_LOADER_CHECKSUM_EN SHALL select trailing-checksum checking.
REQ-035 With the macro defined, SHALL keep a running 16-bit sum (mod 2^16) of the N data words, zero-initialised on start.
REQ-036 With the macro defined, end-of-data SHALL go to CSUM_HI, CSUM_LO, then DONE if the received word equals the sum, else ERROR.
REQ-037 Without the macro, end-of-data SHALL go directly to DONE, and the CSUM states and sum register SHALL be absent.

Verification
REQ-038 Bench SHALL cover: reset, start, bytes 00 02 12 34 AB CD -> writes 0x1234@0 and 0xABCD@1, one mem_wren cycle each, then done=1, cpu_reset=0 (checksum disabled).
REQ-039 Bench SHALL cover: same stream plus checksum bytes BE 01 with OP_LOADER_CHECKSUM_EN -> done=1; with checksum bytes BE 02 -> error=1, cpu_reset=1.
REQ-040 Bench SHALL cover: length 00 00 -> no mem_wren, done=1 (checksum variant expects checksum 00 00).
REQ-041 Bench SHALL cover: length 0x1001 with MAX_WORDS=4096 -> ERROR after the second length byte, no writes.
REQ-042 Bench SHALL cover: rx_valid toggled randomly during a 3-word load -> identical writes and addresses as the back-to-back stream.
REQ-043 Bench SHALL cover: reset asserted in the cycle of the first WRITE -> mem_wren=0 immediately, state IDLE, cpu_reset=1.
